// File: rtl/leve1_wb_if.sv
// leve1_wb_if: execute-to-writeback bundle, decode read ports and retire trace.
// Ports: IVALID/IPC/IINSTR/IWE/IRD/ICSRD in, RS*/CSR_* read ports, RET_* out.
interface leve1_wb_if #(
    parameter int XLEN = 64
);
    logic            IVALID;
    logic [XLEN-1:0] IPC;
    logic [31:0]     IINSTR;
    logic            IWE;
    logic [XLEN-1:0] IRD;
    logic [XLEN-1:0] ICSRD;
    logic [4:0]      RS1_ADDR;
    logic [4:0]      RS2_ADDR;
    logic [XLEN-1:0] RS1_DATA;
    logic [XLEN-1:0] RS2_DATA;
    logic [11:0]     CSR_ADDR;
    logic [XLEN-1:0] CSR_RDATA;
    logic            RET_VALID;
    logic [XLEN-1:0] RET_PC;
    logic [31:0]     RET_INSTR;

    modport master (
        output IVALID, IPC, IINSTR, IWE, IRD, ICSRD,
        output RS1_ADDR, RS2_ADDR, CSR_ADDR,
        input  RS1_DATA, RS2_DATA, CSR_RDATA,
        input  RET_VALID, RET_PC, RET_INSTR
    );

    modport slave (
        input  IVALID, IPC, IINSTR, IWE, IRD, ICSRD,
        input  RS1_ADDR, RS2_ADDR, CSR_ADDR,
        output RS1_DATA, RS2_DATA, CSR_RDATA,
        output RET_VALID, RET_PC, RET_INSTR
    );
endinterface

// File: rtl/leve1_wb.sv
// leve1_wb: write-back stage owning the GPR file and machine CSRs.
// Ports: CLK, RST (sync, active-high), bus (leve1_wb_if.slave).
module leve1_wb #(
    parameter int XLEN = 64
) (
    input  logic     CLK,
    input  logic     RST,
    leve1_wb_if.slave bus
);
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [6:0]  OP_SYSTEM  = 7'b1110011;

    logic [4:0]  rd;
    logic [4:0]  rs1f;
    logic [2:0]  f3;
    logic [11:0] caddr;

    assign rd    = bus.IINSTR[11:7];
    assign rs1f  = bus.IINSTR[19:15];
    assign f3    = bus.IINSTR[14:12];
    assign caddr = bus.IINSTR[31:20];

    // ---------------- GPR file ----------------
    logic            gpr_we;
    logic [XLEN-1:0] gpr_q [32];

    assign gpr_we = bus.IVALID & bus.IWE & (rd != 5'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else if (gpr_we) begin
            gpr_q[rd] <= bus.IRD;
        end
    end

    assign bus.RS1_DATA = (bus.RS1_ADDR == 5'd0) ? '0 :
                          (gpr_we && bus.RS1_ADDR == rd) ? bus.IRD :
                          gpr_q[bus.RS1_ADDR];
    assign bus.RS2_DATA = (bus.RS2_ADDR == 5'd0) ? '0 :
                          (gpr_we && bus.RS2_ADDR == rd) ? bus.IRD :
                          gpr_q[bus.RS2_ADDR];

    // ---------------- CSR file ----------------
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;

    logic            csr_op;
    logic            csr_wen;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] csr_new;
    logic [XLEN-1:0] csr_wval;
    logic            wr_mscratch, wr_mepc, wr_mcause;
    logic            wr_mtvec, wr_mcycle, wr_minstret;
    logic            csr_hit;
    logic [XLEN-1:0] csr_rd_st;

    assign csr_op = bus.IVALID & (bus.IINSTR[6:0] == OP_SYSTEM) & (f3 != 3'b000);

    always_comb begin
        csr_old = '0;
        case (caddr)
            A_MSCRATCH: csr_old = mscratch_q;
            A_MEPC:     csr_old = mepc_q;
            A_MCAUSE:   csr_old = mcause_q;
            A_MTVEC:    csr_old = mtvec_q;
            A_MCYCLE:   csr_old = mcycle_q;
            A_MINSTRET: csr_old = minstret_q;
            default:    csr_old = '0;
        endcase
    end

    // Set/clear forms with rs1 field zero are pure reads.
    always_comb begin
        csr_new = '0;
        csr_wen = 1'b0;
        if (csr_op) begin
            unique case (f3[1:0])
                2'b01: begin
                    csr_new = bus.ICSRD;
                    csr_wen = 1'b1;
                end
                2'b10: begin
                    csr_new = csr_old | bus.ICSRD;
                    csr_wen = (rs1f != 5'd0);
                end
                2'b11: begin
                    csr_new = csr_old & ~bus.ICSRD;
                    csr_wen = (rs1f != 5'd0);
                end
                default: begin
                    csr_new = '0;
                    csr_wen = 1'b0;
                end
            endcase
        end
    end

    assign wr_mscratch = csr_wen & (caddr == A_MSCRATCH);
    assign wr_mepc     = csr_wen & (caddr == A_MEPC);
    assign wr_mcause   = csr_wen & (caddr == A_MCAUSE);
    assign wr_mtvec    = csr_wen & (caddr == A_MTVEC);
    assign wr_mcycle   = csr_wen & (caddr == A_MCYCLE);
    assign wr_minstret = csr_wen & (caddr == A_MINSTRET);
    assign csr_hit     = wr_mscratch | wr_mepc | wr_mcause |
                         wr_mtvec | wr_mcycle | wr_minstret;

    // mepc/mtvec hold 4-byte aligned addresses only.
    assign csr_wval = {csr_new[XLEN-1:2],
                       (wr_mepc | wr_mtvec) ? 2'b00 : csr_new[1:0]};

    assign mscratch_d = wr_mscratch ? csr_wval : mscratch_q;
    assign mepc_d     = wr_mepc     ? csr_wval : mepc_q;
    assign mcause_d   = wr_mcause   ? csr_wval : mcause_q;
    assign mtvec_d    = wr_mtvec    ? csr_wval : mtvec_q;
    // An explicit write replaces the increment for that cycle.
    assign mcycle_d   = wr_mcycle   ? csr_wval : mcycle_q + XLEN'(1);
    assign minstret_d = wr_minstret ? csr_wval :
                        minstret_q + {{(XLEN-1){1'b0}}, bus.IVALID};

    always_ff @(posedge CLK) begin
        if (RST) begin
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtvec_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtvec_q    <= mtvec_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    always_comb begin
        csr_rd_st = '0;
        case (bus.CSR_ADDR)
            A_MSCRATCH: csr_rd_st = mscratch_q;
            A_MEPC:     csr_rd_st = mepc_q;
            A_MCAUSE:   csr_rd_st = mcause_q;
            A_MTVEC:    csr_rd_st = mtvec_q;
            A_MCYCLE:   csr_rd_st = mcycle_q;
            A_MINSTRET: csr_rd_st = minstret_q;
            default:    csr_rd_st = '0;
        endcase
    end

    // Counters read their pre-increment value unless explicitly written.
    assign bus.CSR_RDATA = (csr_hit && bus.CSR_ADDR == caddr) ? csr_wval : csr_rd_st;

    // ---------------- Retire trace ----------------
    logic            ret_valid_q;
    logic [XLEN-1:0] ret_pc_q;
    logic [31:0]     ret_instr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ret_valid_q <= 1'b0;
            ret_pc_q    <= '0;
            ret_instr_q <= '0;
        end else begin
            ret_valid_q <= bus.IVALID;
            ret_pc_q    <= bus.IPC;
            ret_instr_q <= bus.IINSTR;
        end
    end

    assign bus.RET_VALID = ret_valid_q;
    assign bus.RET_PC    = ret_pc_q;
    assign bus.RET_INSTR = ret_instr_q;
endmodule

// File: tb/tb_leve1_wb.sv
// tb_leve1_wb: randomized and directed checks of leve1_wb against a reference model.
// Ports: none; drives leve1_wb_if and clocks the design.
module tb_leve1_wb;
    localparam int XLEN = 64;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    leve1_wb_if #(.XLEN(XLEN)) bus ();

    leve1_wb #(.XLEN(XLEN)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Reference state: index 0..5 = mscratch, mepc, mcause, mtvec, mcycle, minstret
    logic [XLEN-1:0] m_gpr [32];
    logic [XLEN-1:0] m_csr [6];
    logic            m_rv;
    logic [XLEN-1:0] m_rpc;
    logic [31:0]     m_rins;

    function automatic int csr_idx(input logic [11:0] a);
        case (a)
            12'h340: return 0;
            12'h341: return 1;
            12'h342: return 2;
            12'h305: return 3;
            12'hB00: return 4;
            12'hB02: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] csr_ins(input logic [11:0] a, input logic [2:0] f,
                                            input logic [4:0] rs1);
        return {a, rs1, f, 5'd0, 7'h73};
    endfunction

    // Which CSR (if any) the given instruction writes, and with what value.
    function automatic void pend(input logic v, input logic [31:0] ins,
                                 input logic [XLEN-1:0] d,
                                 output int idx, output logic [XLEN-1:0] nv);
        int k;
        logic [XLEN-1:0] old;
        bit wr;
        idx = -1;
        nv = '0;
        wr = 0;
        if (v && ins[6:0] == 7'h73 && ins[14:12] != 3'd0) begin
            k = csr_idx(ins[31:20]);
            old = (k >= 0) ? m_csr[k] : '0;
            if (ins[13:12] == 2'd1) begin nv = d; wr = 1; end
            else if (ins[13:12] == 2'd2) begin nv = old | d; wr = ins[19:15] != 0; end
            else if (ins[13:12] == 2'd3) begin nv = old & ~d; wr = ins[19:15] != 0; end
            if (wr && k >= 0) begin
                idx = k;
                if (k == 1 || k == 3) nv = (nv >> 2) << 2;
            end
        end
    endfunction

    function automatic logic [XLEN-1:0] exp_gpr(input logic [4:0] a);
        if (a == 0) return '0;
        if (bus.IVALID && bus.IWE && bus.IINSTR[11:7] == a) return bus.IRD;
        return m_gpr[a];
    endfunction

    function automatic logic [XLEN-1:0] exp_csr(input logic [11:0] a);
        int idx;
        logic [XLEN-1:0] nv;
        int k;
        pend(bus.IVALID, bus.IINSTR, bus.ICSRD, idx, nv);
        k = csr_idx(a);
        if (k < 0) return '0;
        if (idx == k) return nv;
        return m_csr[k];
    endfunction

    function automatic void model_step(input logic r, input logic v, input logic we,
                                       input logic [31:0] ins, input logic [XLEN-1:0] d,
                                       input logic [XLEN-1:0] c, input logic [XLEN-1:0] pc);
        int idx;
        logic [XLEN-1:0] nv;
        if (r) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = '0;
            for (int i = 0; i < 6; i++) m_csr[i] = '0;
            m_rv = 0;
            m_rpc = '0;
            m_rins = '0;
            return;
        end
        pend(v, ins, c, idx, nv);
        if (v && we && ins[11:7] != 0) m_gpr[ins[11:7]] = d;
        m_csr[4] = m_csr[4] + 1;
        if (v) m_csr[5] = m_csr[5] + 1;
        if (idx >= 0) m_csr[idx] = nv;
        m_rv = v;
        m_rpc = pc;
        m_rins = ins;
    endfunction

    task automatic tick();
        logic r, v, we;
        logic [31:0] ins;
        logic [XLEN-1:0] d, c, pc;
        r = RST; v = bus.IVALID; we = bus.IWE; ins = bus.IINSTR;
        d = bus.IRD; c = bus.ICSRD; pc = bus.IPC;
        @(posedge CLK);
        model_step(r, v, we, ins, d, c, pc);
        #1;
    endtask

    task automatic idle();
        bus.IVALID = 0;
        bus.IWE = 0;
        bus.IINSTR = 32'h0000_0013;
        bus.IPC = '0;
        bus.IRD = '0;
        bus.ICSRD = '0;
        #1;
    endtask

    task automatic csr_op(input logic [11:0] a, input logic [2:0] f,
                          input logic [4:0] rs1, input logic [XLEN-1:0] d);
        bus.IVALID = 1;
        bus.IWE = 0;
        bus.IINSTR = csr_ins(a, f, rs1);
        bus.ICSRD = d;
        bus.CSR_ADDR = a;
        #1;
    endtask

    task automatic test_reset();
        RST = 1;
        bus.IVALID = 1; bus.IWE = 1; bus.IINSTR = 32'h0000_0293;
        bus.IRD = 64'hDEAD; bus.IPC = 64'h40; bus.ICSRD = '0;
        bus.RS1_ADDR = 5; bus.RS2_ADDR = 0; bus.CSR_ADDR = 12'hB00;
        tick();
        idle();
        tick();
        n_checks++;
        if (bus.RS1_DATA !== '0) begin
            n_errors++; $display("FAIL reset_x5 got %h want 0", bus.RS1_DATA);
        end
        n_checks++;
        if (bus.RET_VALID !== 1'b0) begin
            n_errors++; $display("FAIL reset_ret_valid got %b want 0", bus.RET_VALID);
        end
        n_checks++;
        if (bus.CSR_RDATA !== '0) begin
            n_errors++; $display("FAIL reset_mcycle got %h want 0", bus.CSR_RDATA);
        end
        RST = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (bus.CSR_RDATA !== XLEN'(i) || m_csr[4] !== XLEN'(i)) begin
                n_errors++; $display("FAIL mcycle_count got %h want %0d", bus.CSR_RDATA, i);
            end
        end
    endtask

    task automatic test_gpr_bypass();
        bus.IVALID = 1; bus.IWE = 1; bus.IINSTR = 32'h0000_0393;
        bus.IRD = 64'h1234; bus.RS1_ADDR = 7; bus.RS2_ADDR = 7;
        #1;
        n_checks++;
        if (bus.RS1_DATA !== 64'h1234) begin
            n_errors++; $display("FAIL gpr_bypass got %h want 1234", bus.RS1_DATA);
        end
        tick();
        idle();
        n_checks++;
        if (bus.RS2_DATA !== 64'h1234) begin
            n_errors++; $display("FAIL gpr_x7 got %h want 1234", bus.RS2_DATA);
        end
        bus.IVALID = 1; bus.IWE = 1; bus.IINSTR = 32'h0000_0013;
        bus.IRD = 64'hFFFF; bus.RS1_ADDR = 0;
        #1;
        n_checks++;
        if (bus.RS1_DATA !== '0) begin
            n_errors++; $display("FAIL gpr_x0_bypass got %h want 0", bus.RS1_DATA);
        end
        tick();
        idle();
        n_checks++;
        if (bus.RS1_DATA !== '0) begin
            n_errors++; $display("FAIL gpr_x0 got %h want 0", bus.RS1_DATA);
        end
    endtask

    task automatic test_csr_set_clear();
        csr_op(12'h340, 3'b001, 5'd1, 64'h0F);
        tick();
        csr_op(12'h340, 3'b010, 5'd3, 64'hF0);
        n_checks++;
        if (bus.CSR_RDATA !== 64'hFF) begin
            n_errors++; $display("FAIL csrrs_bypass got %h want ff", bus.CSR_RDATA);
        end
        tick();
        csr_op(12'h340, 3'b010, 5'd0, 64'hFF00);
        n_checks++;
        if (bus.CSR_RDATA !== 64'hFF) begin
            n_errors++; $display("FAIL csrrs_x0 got %h want ff", bus.CSR_RDATA);
        end
        tick();
        csr_op(12'h340, 3'b011, 5'd4, 64'h0F);
        tick();
        idle();
        n_checks++;
        if (bus.CSR_RDATA !== 64'hF0) begin
            n_errors++; $display("FAIL csrrc got %h want f0", bus.CSR_RDATA);
        end
    endtask

    task automatic test_minstret();
        logic [5:0] pat;
        pat = 6'b110101;
        csr_op(12'hB02, 3'b001, 5'd1, '0);
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.IVALID = pat[i]; bus.IWE = 0; bus.IINSTR = 32'h0000_0013;
            tick();
        end
        idle();
        n_checks++;
        if (bus.CSR_RDATA !== 64'd4) begin
            n_errors++; $display("FAIL minstret_count got %0d want 4", bus.CSR_RDATA);
        end
        csr_op(12'hB02, 3'b001, 5'd2, 64'd100);
        tick();
        idle();
        n_checks++;
        if (bus.CSR_RDATA !== 64'd100) begin
            n_errors++; $display("FAIL minstret_write got %0d want 100", bus.CSR_RDATA);
        end
        csr_op(12'hB02, 3'b001, 5'd2, '1);
        tick();
        bus.IINSTR = 32'h0000_0013; bus.IVALID = 1;
        tick();
        idle();
        n_checks++;
        if (bus.CSR_RDATA !== '0) begin
            n_errors++; $display("FAIL minstret_wrap got %h want 0", bus.CSR_RDATA);
        end
        csr_op(12'hB00, 3'b001, 5'd2, '1);
        tick();
        idle();
        n_checks++;
        if (bus.CSR_RDATA !== '1) begin
            n_errors++; $display("FAIL mcycle_write got %h want all-ones", bus.CSR_RDATA);
        end
        tick();
        n_checks++;
        if (bus.CSR_RDATA !== '0) begin
            n_errors++; $display("FAIL mcycle_wrap got %h want 0", bus.CSR_RDATA);
        end
    endtask

    task automatic test_mtvec();
        csr_op(12'h305, 3'b101, 5'd3, 64'h8000_0003);
        n_checks++;
        if (bus.CSR_RDATA !== 64'h8000_0000) begin
            n_errors++; $display("FAIL mtvec_bypass got %h want 80000000", bus.CSR_RDATA);
        end
        tick();
        idle();
        n_checks++;
        if (bus.CSR_RDATA !== 64'h8000_0000) begin
            n_errors++; $display("FAIL mtvec_align got %h want 80000000", bus.CSR_RDATA);
        end
        csr_op(12'h7C0, 3'b001, 5'd3, 64'h55);
        tick();
        idle();
        n_checks++;
        if (bus.CSR_RDATA !== '0) begin
            n_errors++; $display("FAIL unmapped got %h want 0", bus.CSR_RDATA);
        end
    endtask

    task automatic test_retire();
        bus.IVALID = 1; bus.IWE = 1; bus.IRD = 64'd1;
        bus.IPC = 64'h8000_0010; bus.IINSTR = 32'h0010_0093;
        tick();
        idle();
        n_checks++;
        if (bus.RET_VALID !== 1'b1 || bus.RET_PC !== 64'h8000_0010 ||
            bus.RET_INSTR !== 32'h0010_0093) begin
            n_errors++;
            $display("FAIL retire got v=%b pc=%h ins=%h want 1 80000010 00100093",
                     bus.RET_VALID, bus.RET_PC, bus.RET_INSTR);
        end
        RST = 1;
        tick();
        RST = 0;
        n_checks++;
        if (bus.RET_VALID !== 1'b0 || bus.RET_PC !== '0) begin
            n_errors++; $display("FAIL retire_reset got v=%b pc=%h want 0 0",
                                 bus.RET_VALID, bus.RET_PC);
        end
    endtask

    task automatic test_random();
        logic [11:0] alist [8];
        logic [11:0] a;
        logic [4:0] rs1;
        alist = '{12'h340, 12'h341, 12'h342, 12'h305, 12'hB00, 12'hB02, 12'h7C0, 12'h000};
        for (int n = 0; n < 400; n++) begin
            RST = ($urandom_range(0, 49) == 0);
            bus.IVALID = $urandom_range(0, 3) != 0;
            bus.IWE = $urandom_range(0, 1);
            bus.IPC = {$urandom, $urandom};
            bus.IRD = {$urandom, $urandom};
            bus.ICSRD = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                a = alist[$urandom_range(0, 7)];
                rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                bus.IINSTR = {a, rs1, 3'($urandom_range(0, 7)), 5'($urandom), 7'h73};
            end else begin
                bus.IINSTR = {$urandom} & 32'hFFFF_FFB3 | 32'h13;
            end
            bus.RS1_ADDR = ($urandom_range(0, 2) == 0) ? bus.IINSTR[11:7] : 5'($urandom);
            bus.RS2_ADDR = 5'($urandom);
            bus.CSR_ADDR = ($urandom_range(0, 1) == 0) ? bus.IINSTR[31:20]
                                                       : alist[$urandom_range(0, 7)];
            #1;
            n_checks++;
            if (bus.RS1_DATA !== exp_gpr(bus.RS1_ADDR) ||
                bus.RS2_DATA !== exp_gpr(bus.RS2_ADDR)) begin
                n_errors++;
                $display("FAIL rand_gpr n=%0d got %h/%h want %h/%h", n, bus.RS1_DATA,
                         bus.RS2_DATA, exp_gpr(bus.RS1_ADDR), exp_gpr(bus.RS2_ADDR));
            end
            n_checks++;
            if (bus.CSR_RDATA !== exp_csr(bus.CSR_ADDR)) begin
                n_errors++;
                $display("FAIL rand_csr n=%0d addr=%h got %h want %h", n, bus.CSR_ADDR,
                         bus.CSR_RDATA, exp_csr(bus.CSR_ADDR));
            end
            tick();
            n_checks++;
            if (bus.RET_VALID !== m_rv || bus.RET_PC !== m_rpc || bus.RET_INSTR !== m_rins) begin
                n_errors++;
                $display("FAIL rand_retire n=%0d got %b %h %h want %b %h %h", n,
                         bus.RET_VALID, bus.RET_PC, bus.RET_INSTR, m_rv, m_rpc, m_rins);
            end
        end
        RST = 0;
        idle();
    endtask

    initial begin
        idle();
        bus.RS1_ADDR = 0;
        bus.RS2_ADDR = 0;
        bus.CSR_ADDR = 0;
        test_reset();
        test_gpr_bypass();
        test_csr_set_clear();
        test_minstret();
        test_mtvec();
        test_retire();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
